// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and data access (DM); each access runs IDLE -> ISSUE -> WAIT -> RESP.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              DM_REQ,
  input  logic              DM_WR,
  input  logic [ADDR_W-1:0] DM_ADDR,
  input  logic [DATA_W-1:0] DM_WDATA,
  output logic              DM_ACK,
  output logic [DATA_W-1:0] DM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WR,
  output logic [DATA_W-1:0] MEM_DATAIN,
  input  logic [DATA_W-1:0] MEM_DATAOUT,
  output logic              BUSY,
  output logic [1:0]        STATE
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_gnt_q, last_gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      gnt_q      <= GNT_IF;
      last_gnt_q <= GNT_DM;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // NOTE: every signal gets a hold default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (IF_REQ || DM_REQ) begin
          if (IF_REQ && DM_REQ) gnt_d = (last_gnt_q == GNT_DM) ? GNT_IF : GNT_DM;
          else                  gnt_d = IF_REQ ? GNT_IF : GNT_DM;
          last_gnt_d = gnt_d;
          // Write data is only captured for DM; fetches leave MEM_DATAIN as is.
          if (gnt_d == GNT_DM) begin
            addr_d  = DM_ADDR;
            wr_d    = DM_WR;
            wdata_d = DM_WDATA;
          end else begin
            addr_d  = IF_ADDR;
            wr_d    = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(LAT - 1);
        state_d = (LAT == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_RESP;
      end
      S_RESP: begin
        if (!wr_q) begin
          if (gnt_q == GNT_IF) if_rdata_d = MEM_DATAOUT;
          else                 dm_rdata_d = MEM_DATAOUT;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IF_ACK     = (state_q == S_RESP) && (gnt_q == GNT_IF);
  assign DM_ACK     = (state_q == S_RESP) && (gnt_q == GNT_DM);
  // Read data is forwarded straight from memory during RESP.
  assign IF_RDATA   = (IF_ACK && !wr_q) ? MEM_DATAOUT : if_rdata_q;
  assign DM_RDATA   = (DM_ACK && !wr_q) ? MEM_DATAOUT : dm_rdata_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WR     = (state_q == S_ISSUE) && wr_q;
  assign MEM_DATAIN = wdata_q;
  assign BUSY       = (state_q != S_IDLE);
  assign STATE      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a LAT=2 instance for the main
// scenarios and a LAT=1 instance for the short path.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_errors;

  logic        if_req, if_ack, dm_req, dm_wr, dm_ack, mem_wr, busy;
  logic [31:0] if_addr, dm_addr, mem_addr;
  logic [63:0] if_rdata, dm_wdata, dm_rdata, mem_datain, mem_dataout;
  logic [1:0]  state;

  logic        b_if_req, b_if_ack, b_dm_req, b_dm_wr, b_dm_ack, b_mem_wr, b_busy;
  logic [31:0] b_if_addr, b_dm_addr, b_mem_addr;
  logic [63:0] b_if_rdata, b_dm_wdata, b_dm_rdata, b_mem_datain, b_mem_dataout;
  logic [1:0]  b_state;

  localparam logic [63:0] STORE_DATA = 64'hDEADBEEFCAFEF00D;

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 64'h0000000000500093;
    return {~a, a};
  endfunction

  assign mem_dataout   = mem_val(mem_addr);
  assign b_mem_dataout = mem_val(b_mem_addr);

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .LAT(2)) u_dut (
    .CLK(clk), .RESET_N(rst_n),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
    .DM_REQ(dm_req), .DM_WR(dm_wr), .DM_ADDR(dm_addr), .DM_WDATA(dm_wdata),
    .DM_ACK(dm_ack), .DM_RDATA(dm_rdata),
    .MEM_ADDR(mem_addr), .MEM_WR(mem_wr), .MEM_DATAIN(mem_datain),
    .MEM_DATAOUT(mem_dataout), .BUSY(busy), .STATE(state)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(64), .LAT(1)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n),
    .IF_REQ(b_if_req), .IF_ADDR(b_if_addr), .IF_ACK(b_if_ack), .IF_RDATA(b_if_rdata),
    .DM_REQ(b_dm_req), .DM_WR(b_dm_wr), .DM_ADDR(b_dm_addr), .DM_WDATA(b_dm_wdata),
    .DM_ACK(b_dm_ack), .DM_RDATA(b_dm_rdata),
    .MEM_ADDR(b_mem_addr), .MEM_WR(b_mem_wr), .MEM_DATAIN(b_mem_datain),
    .MEM_DATAOUT(b_mem_dataout), .BUSY(b_busy), .STATE(b_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial begin
    int ack_cnt;
    n_checks = 0;
    n_errors = 0;
    rst_n  = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_wr = 1'b0; dm_addr = '0; dm_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_dm_req = 1'b0; b_dm_wr = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_state", state, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_acks", {if_ack, dm_ack}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // IF read at 0x10
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("t1_issue_state", state, 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_mem_wr", mem_wr, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_wait_state", state, 2);
    check("t1_no_early_ack", if_ack, 0);
    @(negedge clk);
    check("t1_resp_state", state, 3);
    check("t1_if_ack", if_ack, 1);
    check("t1_dm_ack", dm_ack, 0);
    check("t1_if_rdata", if_rdata, 64'h0000000000500093);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_idle", state, 0);
    check("t1_ack_gone", if_ack, 0);
    check("t1_rdata_hold", if_rdata, 64'h0000000000500093);

    // DM store; inputs change after grant and must be ignored
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h100; dm_wdata = STORE_DATA;
    @(negedge clk);
    check("t2_issue_state", state, 1);
    check("t2_mem_wr", mem_wr, 1);
    check("t2_mem_addr", mem_addr, 32'h100);
    check("t2_mem_datain", mem_datain, STORE_DATA);
    dm_wr = 1'b0; dm_addr = 32'h999; dm_wdata = '0;
    @(negedge clk);
    check("t2_wait_mem_wr", mem_wr, 0);
    check("t2_wait_state", state, 2);
    check("t2_wait_addr", mem_addr, 32'h100);
    @(negedge clk);
    check("t2_dm_ack", dm_ack, 1);
    check("t2_if_ack", if_ack, 0);
    check("t2_resp_mem_wr", mem_wr, 0);
    check("t2_dm_rdata_keep", dm_rdata, 0);
    dm_req = 1'b0;
    @(negedge clk);
    check("t2_idle", state, 0);
    check("t2_datain_hold", mem_datain, STORE_DATA);
    check("t2_rdata_after", dm_rdata, 0);

    // DM load with DM_REQ dropped during WAIT
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h200;
    @(negedge clk);
    check("t6_mem_addr", mem_addr, 32'h200);
    check("t6_mem_wr", mem_wr, 0);
    @(negedge clk);
    check("t6_wait_state", state, 2);
    dm_req = 1'b0;
    @(negedge clk);
    check("t6_dm_ack", dm_ack, 1);
    check("t6_dm_rdata", dm_rdata, mem_val(32'h200));
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ack_cnt += int'(dm_ack) + int'(busy);
    end
    check("t6_no_second_access", ack_cnt, 0);
    check("t6_rdata_hold", dm_rdata, mem_val(32'h200));
    check("t6_if_rdata_untouched", if_rdata, 64'h0000000000500093);

    // Both requesting continuously from reset release
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h300;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("t3_if_ack_c%0d", k), if_ack, (k == 3 || k == 11));
      check($sformatf("t3_dm_ack_c%0d", k), dm_ack, (k == 7 || k == 15));
      if (k == 3)  check("t3_if_rdata", if_rdata, mem_val(32'h20));
      if (k == 5)  check("t3_dm_grant_addr", mem_addr, 32'h300);
      if (k == 7)  check("t3_dm_rdata", dm_rdata, mem_val(32'h300));
      if (k == 15) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    @(negedge clk);
    check("t3_idle", state, 0);

    // Reset during WAIT of a DM store
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 32'h400; dm_wdata = 64'h1234;
    @(negedge clk);
    check("t4_mem_wr", mem_wr, 1);
    @(negedge clk);
    check("t4_wait_state", state, 2);
    #1 rst_n = 1'b0;
    #1;
    check("t4_rst_state", state, 0);
    check("t4_rst_mem_wr", mem_wr, 0);
    check("t4_rst_busy", busy, 0);
    dm_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ack_cnt += int'(if_ack) + int'(dm_ack);
    end
    check("t4_no_ack_after_rst", ack_cnt, 0);
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 32'h500;
    @(negedge clk);
    check("t4_if_first_addr", mem_addr, 32'h40);
    repeat (2) @(negedge clk);
    check("t4_if_ack", if_ack, 1);
    check("t4_dm_ack", dm_ack, 0);
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    check("t4_idle", state, 0);

    // LAT=1 instance, single DM load
    b_dm_req = 1'b1; b_dm_wr = 1'b0; b_dm_addr = 32'h600;
    @(negedge clk);
    check("t5_issue_state", b_state, 1);
    check("t5_no_early_ack", b_dm_ack, 0);
    @(negedge clk);
    check("t5_resp_state", b_state, 3);
    check("t5_dm_ack", b_dm_ack, 1);
    check("t5_dm_rdata", b_dm_rdata, mem_val(32'h600));
    b_dm_req = 1'b0;
    @(negedge clk);
    check("t5_idle", b_state, 0);
    check("t5_ack_gone", b_dm_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
